// File: rtl/dcf77_pkg.sv
// Shared definitions for the DCF77 clock: time-field width, field limits,
// a packed time-of-day record and the helpers used on it.
package dcf77_pkg;

  localparam int TIME_W   = 7;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  typedef logic [TIME_W-1:0] time_field_t;

  typedef struct packed {
    time_field_t ore;
    time_field_t minuti;
    time_field_t secondi;
  } tod_t;

  localparam time_field_t SEC_LAST  = time_field_t'(SEC_MAX);
  localparam time_field_t MIN_LAST  = time_field_t'(MIN_MAX);
  localparam time_field_t HOUR_LAST = time_field_t'(HOUR_MAX);

  // A decoded frame is only usable when both fields are in range.
  function automatic logic load_in_range(time_field_t m, time_field_t h);
    return (m <= MIN_LAST) && (h <= HOUR_LAST);
  endfunction

  // One-second advance with the full carry chain (23:59:59 -> 00:00:00).
  function automatic tod_t advance_one_second(tod_t t);
    tod_t n;
    n = t;
    if (t.secondi != SEC_LAST) begin
      n.secondi = t.secondi + time_field_t'(1);
    end else begin
      n.secondi = '0;
      if (t.minuti != MIN_LAST) begin
        n.minuti = t.minuti + time_field_t'(1);
      end else begin
        n.minuti = '0;
        n.ore    = (t.ore == HOUR_LAST) ? '0 : t.ore + time_field_t'(1);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/module_tick_divider.sv
// Free-running prescaler: counts 0..DIV-1 and raises tick for the single
// cycle in which the count sits at its terminal value.
module module_tick_divider #(
  parameter int DIV = 50000000
) (
  input  logic clk_in,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == TERM);

  // Count up with wrap; clr restarts the second from zero.
  // NOTE: clocked state is written with <= so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/module_timekeeper.sv
// Time-of-day keeper for the DCF77 clock: 1 Hz free-running seconds,
// minutes and hours, realigned on every valid decoded minute frame, with a
// holdover counter that drops sincronizzato after too long without a load.
module module_timekeeper
  import dcf77_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int HOLDOVER_MIN = 60
) (
  input  logic              clk_in,
  input  logic              GSR,
  input  logic              load_strobe,
  input  logic [TIME_W-1:0] load_minuti,
  input  logic [TIME_W-1:0] load_ore,
  output logic [TIME_W-1:0] secondi,
  output logic [TIME_W-1:0] minuti,
  output logic [TIME_W-1:0] ore,
  output logic              flag_sincro,
  output logic              sincronizzato
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLDOVER_MIN);

  logic       tick;
  logic       valid_load;
  logic       minute_carry;
  tod_t       now_q;
  logic [7:0] holdover;
  logic [7:0] holdover_inc;

  assign valid_load   = load_strobe && load_in_range(load_minuti, load_ore);
  assign minute_carry = (now_q.secondi == SEC_LAST);
  assign holdover_inc = (holdover == HOLD_LAST) ? holdover : holdover + 8'd1;

  // A valid load restarts the second so the first tick lands a full second later.
  module_tick_divider #(
    .DIV (CLK_HZ)
  ) u_tick_divider (
    .clk_in (clk_in),
    .clr    (GSR || valid_load),
    .tick   (tick)
  );

  // Time registers, holdover tracking and the conversion-start flag.
  // NOTE: reset is synchronous and sits first, so it also cancels a load in the same cycle.
  always_ff @(posedge clk_in) begin
    if (GSR) begin
      now_q         <= '0;
      holdover      <= '0;
      sincronizzato <= 1'b0;
      flag_sincro   <= 1'b0;
    end else if (valid_load) begin
      // A load beats a coincident tick; the tick is simply dropped.
      now_q.secondi <= '0;
      now_q.minuti  <= load_minuti;
      now_q.ore     <= load_ore;
      holdover      <= '0;
      sincronizzato <= 1'b1;
      flag_sincro   <= 1'b1;
    end else if (tick) begin
      now_q       <= advance_one_second(now_q);
      flag_sincro <= 1'b1;
      if (minute_carry) begin
        holdover <= holdover_inc;
        if (holdover_inc == HOLD_LAST) begin
          sincronizzato <= 1'b0;
        end
      end
    end else begin
      flag_sincro <= 1'b0;
    end
  end

  assign secondi = now_q.secondi;
  assign minuti  = now_q.minuti;
  assign ore     = now_q.ore;

endmodule

// File: tb/tb_module_timekeeper.sv
// Bench for module_timekeeper: a seconds-of-day reference model checked
// every cycle, directed scenarios with literal expectations, then random
// loads, resets and free-running stretches.
module tb_module_timekeeper;

  localparam int CLK_HZ       = 20;
  localparam int HOLDOVER_MIN = 2;

  logic       clk_in = 1'b0;
  logic       GSR;
  logic       load_strobe;
  logic [6:0] load_minuti;
  logic [6:0] load_ore;
  logic [6:0] secondi;
  logic [6:0] minuti;
  logic [6:0] ore;
  logic       flag_sincro;
  logic       sincronizzato;

  int n_compared   = 0;
  int n_mismatched = 0;

  module_timekeeper #(
    .CLK_HZ       (CLK_HZ),
    .HOLDOVER_MIN (HOLDOVER_MIN)
  ) dut (
    .clk_in        (clk_in),
    .GSR           (GSR),
    .load_strobe   (load_strobe),
    .load_minuti   (load_minuti),
    .load_ore      (load_ore),
    .secondi       (secondi),
    .minuti        (minuti),
    .ore           (ore),
    .flag_sincro   (flag_sincro),
    .sincronizzato (sincronizzato)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: time as seconds since midnight, plus the number of
  // clk_in cycles elapsed in the current second.
  int tod_s      = 0;
  int phase      = 0;
  int hold_min   = 0;
  bit m_sync     = 1'b0;
  bit m_flag     = 1'b0;
  bit model_live = 1'b0;

  always @(posedge clk_in) begin
    bit tick_now;
    bit load_ok;
    if (GSR) begin
      tod_s = 0; phase = 0; hold_min = 0; m_sync = 0; m_flag = 0;
      model_live = 1'b1;
    end else begin
      tick_now = (phase == CLK_HZ - 1);
      phase    = (phase + 1) % CLK_HZ;
      load_ok  = load_strobe && (int'(load_minuti) <= 59) && (int'(load_ore) <= 23);
      if (load_ok) begin
        tod_s    = int'(load_ore) * 3600 + int'(load_minuti) * 60;
        phase    = 0;
        hold_min = 0;
        m_sync   = 1;
        m_flag   = 1;
      end else if (tick_now) begin
        tod_s  = (tod_s + 1) % 86400;
        m_flag = 1;
        if (tod_s % 60 == 0) begin
          if (hold_min < HOLDOVER_MIN) hold_min++;
          if (hold_min == HOLDOVER_MIN) m_sync = 0;
        end
      end else begin
        m_flag = 0;
      end
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk_in) begin
    if (model_live) begin
      check("model_secondi", int'(secondi), tod_s % 60);
      check("model_minuti",  int'(minuti),  (tod_s / 60) % 60);
      check("model_ore",     int'(ore),     tod_s / 3600);
      check("model_flag",    int'(flag_sincro),   int'(m_flag));
      check("model_sync",    int'(sincronizzato), int'(m_sync));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Called on a negedge; the load is sampled at the next posedge.
  task automatic pulse_load(input int m, input int h);
    load_strobe = 1'b1;
    load_minuti = 7'(m);
    load_ore    = 7'(h);
    @(negedge clk_in);
    load_strobe = 1'b0;
  endtask

  // Waits for the next flag_sincro; returns the number of negedges taken.
  task automatic wait_flag(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!flag_sincro && n < budget);
    if (!flag_sincro) check("flag_timeout", 0, 1);
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s);
    check({name, "_ore"},     int'(ore),     h);
    check({name, "_minuti"},  int'(minuti),  m);
    check({name, "_secondi"}, int'(secondi), s);
  endtask

  initial begin
    int n;
    GSR = 1'b1; load_strobe = 1'b0; load_minuti = '0; load_ore = '0;
    step(2);
    GSR = 1'b0;

    // Run to 00:00:37, then reset mid-count.
    step(37 * CLK_HZ);
    check_time("pre_reset", 0, 0, 37);
    GSR = 1'b1;
    step(1);
    check_time("reset", 0, 0, 0);
    check("reset_flag", int'(flag_sincro), 0);
    check("reset_sync", int'(sincronizzato), 0);
    GSR = 1'b0;
    wait_flag(100, n);
    check("first_tick_latency", n, CLK_HZ);
    check_time("first_tick", 0, 0, 1);

    // Valid load 23:59, then 60 ticks roll over to midnight.
    pulse_load(59, 23);
    check_time("load_2359", 23, 59, 0);
    check("load_2359_flag", int'(flag_sincro), 1);
    check("load_2359_sync", int'(sincronizzato), 1);
    step(1);
    check("load_2359_flag_drop", int'(flag_sincro), 0);
    repeat (60) wait_flag(100, n);
    check_time("midnight", 0, 0, 0);
    check("midnight_sync", int'(sincronizzato), 1);

    // Out-of-range minutes: ignored.
    pulse_load(60, 5);
    check_time("bad_load", 0, 0, 0);
    check("bad_load_flag", int'(flag_sincro), 0);
    check("bad_load_sync", int'(sincronizzato), 1);

    // Load coinciding with a tick: load wins, prescaler restarts.
    wait_flag(100, n);
    step(CLK_HZ - 1);
    pulse_load(20, 10);
    check_time("load_on_tick", 10, 20, 0);
    check("load_on_tick_flag", int'(flag_sincro), 1);
    wait_flag(100, n);
    check("load_on_tick_restart", n, CLK_HZ);
    check_time("after_restart", 10, 20, 1);

    // Holdover: sync drops on the second unaided minute carry.
    repeat (59) wait_flag(100, n);
    check_time("carry1", 10, 21, 0);
    check("carry1_sync", int'(sincronizzato), 1);
    repeat (60) wait_flag(100, n);
    check_time("carry2", 10, 22, 0);
    check("carry2_sync", int'(sincronizzato), 0);

    // Back-to-back: tick just shown, load in the very next cycle.
    pulse_load(30, 5);
    check_time("b2b_load", 5, 30, 0);
    check("b2b_flag", int'(flag_sincro), 1);
    check("b2b_sync", int'(sincronizzato), 1);
    step(1);
    check("b2b_flag_drop", int'(flag_sincro), 0);

    // Random mix of resets, loads (valid and invalid) and idle stretches.
    repeat (400) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        GSR = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          load_strobe = 1'b1;
          load_minuti = 7'($urandom_range(0, 59));
          load_ore    = 7'($urandom_range(0, 23));
        end
        step(1);
        GSR = 1'b0;
        load_strobe = 1'b0;
      end else if (r < 15) begin
        pulse_load($urandom_range(0, 70), $urandom_range(0, 30));
      end else begin
        step($urandom_range(1, 40));
      end
    end

    // Long free run: holdover saturates and sync stays low.
    pulse_load(58, 23);
    step(4 * 60 * CLK_HZ);
    check_time("free_run", 0, 2, 0);
    check("free_run_sync", int'(sincronizzato), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
